// File: rtl/sphere_pkg.sv
// Shared types and constants for the sphere hit scheduler.
// Holds the FSM state encoding, datapath widths and the no-hit distance.
package sphere_pkg;

  localparam int RD_W   = 24;
  localparam int DIST_W = 32;

  localparam logic [DIST_W-1:0] MAX_DIST = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sphere_hit_scheduler.sv
// Walks the spheres of one ray through the distance calculator and keeps the nearest hit.
// Optional SPHERE_SCHED_SKIP_MISS_EN: quick-rejected spheres skip the distance calculator.
module sphere_hit_scheduler
  import sphere_pkg::*;
#(
  parameter int NUM_SPHERES = 8,
  parameter int IDX_W       = $clog2(NUM_SPHERES)
) (
  input  logic                     CLK,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [IDX_W:0]           sphere_count,
  output logic                     busy,
  output logic                     sph_req,
  output logic [IDX_W-1:0]         sph_idx,
  input  logic                     sph_valid,
  input  logic [RD_W-1:0]          sph_root_disc,
  input  logic signed [DIST_W-1:0] sph_b,
  input  logic                     sph_quick_isect,
  output logic [RD_W-1:0]          dc_root_disc,
  output logic signed [DIST_W-1:0] dc_b,
  output logic                     dc_quick_isect,
  output logic [DIST_W-1:0]        dc_old_dist,
  output logic                     dc_in_valid,
  input  logic                     dc_in_ready,
  input  logic                     dc_out_ready,
  input  logic                     dc_intersects,
  input  logic [DIST_W-1:0]        dc_distance,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx,
  output logic [DIST_W-1:0]        hit_dist
);

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_SPHERES);

  state_e                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W:0]             count_q;
  logic [DIST_W-1:0]          best_q;
  logic                       hit_q;
  logic [IDX_W-1:0]           hidx_q;
  logic [RD_W-1:0]            rd_q;
  logic signed [DIST_W-1:0]   b_q;
  logic                       qi_q;

  logic [IDX_W:0] count_d;
  logic [IDX_W:0] idx_d;
  logic           last;

  assign count_d = (sphere_count > MAX_CNT) ? MAX_CNT : sphere_count;
  assign idx_d   = {1'b0, idx_q} + (IDX_W+1)'(1);
  assign last    = (idx_d == count_q);

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      best_q  <= '0;
      hit_q   <= 1'b0;
      hidx_q  <= '0;
      rd_q    <= '0;
      b_q     <= '0;
      qi_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q   <= '0;
            best_q  <= MAX_DIST;
            hit_q   <= 1'b0;
            hidx_q  <= '0;
            count_q <= count_d;
            state_q <= (sphere_count == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (sph_valid) begin
            rd_q <= sph_root_disc;
            b_q  <= sph_b;
            qi_q <= sph_quick_isect;
`ifdef SPHERE_SCHED_SKIP_MISS_EN
            if (!sph_quick_isect) begin
              if (!last) idx_q <= idx_d[IDX_W-1:0];
              state_q <= last ? ST_DONE : ST_FETCH;
            end else begin
              state_q <= ST_ISSUE;
            end
`else
            state_q <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          if (dc_in_ready) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dc_out_ready) begin
            // Calculator already rejects t >= old distance, so no compare here.
            if (dc_intersects) begin
              best_q <= dc_distance;
              hidx_q <= idx_q;
              hit_q  <= 1'b1;
            end
            if (!last) idx_q <= idx_d[IDX_W-1:0];
            state_q <= last ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: begin
          if (result_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign sph_req        = (state_q == ST_FETCH);
  assign sph_idx        = idx_q;
  assign dc_root_disc   = rd_q;
  assign dc_b           = b_q;
  assign dc_quick_isect = qi_q;
  assign dc_old_dist    = best_q;
  assign dc_in_valid    = (state_q == ST_ISSUE) && dc_in_ready;
  assign result_valid   = (state_q == ST_DONE);
  assign hit            = hit_q;
  assign hit_idx        = hidx_q;
  assign hit_dist       = best_q;

endmodule
